// File: rtl/apb_arb_pkg.sv
// Shared types for the APB arbitrating master: FSM state encoding and the
// latched request record.
package apb_arb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  // The bus is word addressed; the two byte-lane bits are always driven low.
  function automatic logic [APB_ADDR_W-1:0] word_align(input logic [APB_ADDR_W-1:0] a);
    return {a[APB_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/apb_if.sv
// Plain APB signal bundle with master and slave views.
interface apb_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_arb_master_rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1 (mod N) for the first
// requester that is pending and not masked. last_grant moves only on advance.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand;
  logic [N-1:0]     elig;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % N);
  endfunction

  assign elig = req & ~mask;

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = wrap_idx(int'(last_q) + k);
      if (elig[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Remember the winner only when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (advance) last_d = grant_idx;
  end

  // Reset to N-1 so requester 0 is first in line.
  always_ff @(posedge pclk) begin
    if (!presetn) last_q <= IDX_W'(N - 1);
    else          last_q <= last_d;
  end

endmodule

// File: rtl/apb_arb_master.sv
// Shares one APB bus among N_REQ single-word requesters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | bus idle; grant an eligible requester and latch its fields
//   ST_SETUP  | psel=1, penable=0; always moves to ACCESS
//   ST_ACCESS | psel=1, penable=1; wait for pready or timeout
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int BUS_ADDR_WIDTH = APB_ADDR_W,
  parameter int BUS_DATA_WIDTH = APB_DATA_W,
  parameter int TIMEOUT        = 16
) (
  input  logic                                  pclk,
  input  logic                                  presetn,
  apb_if.master                                 apb,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ-1:0]                      req_write,
  input  logic [N_REQ-1:0][BUS_ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_REQ-1:0][BUS_DATA_WIDTH-1:0]  req_wdata,
  output logic [N_REQ-1:0]                      rsp_done,
  output logic [BUS_DATA_WIDTH-1:0]             rsp_rdata,
  output logic                                  rsp_err,
  output logic                                  busy
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  apb_state_e                state_q, state_d;
  apb_req_t                  req_q, req_d;
  logic [IDX_W-1:0]          gidx_q, gidx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N_REQ-1:0]          done_q, done_d;
  logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [N_REQ-1:0]          arb_grant;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_advance;
  logic                      timed_out;

  // The requester just completed is masked for one IDLE cycle so its
  // still-high req_valid cannot re-issue the finished transfer.
  rr_arbiter #(.N(N_REQ)) u_arb (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req_valid),
    .mask      (done_q),
    .advance   (arb_advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Counter holds the number of wait cycles already spent; the current
  // wait cycle is the T-th when it reads T-1.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

  // Next-state, latch and response logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    done_d      = '0;
    rdata_d     = '0;
    err_d       = 1'b0;
    arb_advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          arb_advance = 1'b1;
          gidx_d      = arb_idx;
          req_d.write = req_write[arb_idx];
          req_d.addr  = word_align(req_addr[arb_idx]);
          req_d.wdata = req_wdata[arb_idx];
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.pready) begin
          done_d[gidx_q] = 1'b1;
          err_d          = apb.pslverr;
          rdata_d        = req_q.write ? '0 : apb.prdata;
          state_d        = ST_IDLE;
        end else if (timed_out) begin
          done_d[gidx_q] = 1'b1;
          err_d          = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign apb.paddr   = req_q.addr;
  assign apb.psel    = (state_q != ST_IDLE);
  assign apb.penable = (state_q == ST_ACCESS);
  assign apb.pwrite  = req_q.write;
  assign apb.pwdata  = req_q.wdata;

  assign rsp_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_arb_master.sv
// Transaction-level bench: requesters and an APB slave are driven from
// queues or $urandom; each transfer's expected grant, bus fields, length and
// response are computed from the round-robin and timeout rules.
module tb_apb_arb_master;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int T  = 4;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } tb_req_t;

  logic                 pclk    = 1'b0;
  logic                 presetn = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_write = '0;
  logic [N-1:0][AW-1:0] req_addr  = '0;
  logic [N-1:0][DW-1:0] req_wdata = '0;
  logic [N-1:0]         rsp_done;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 busy;

  apb_if #(.AW(AW), .DW(DW)) bus ();

  apb_arb_master #(
    .N_REQ(N), .BUS_ADDR_WIDTH(AW), .BUS_DATA_WIDTH(DW), .TIMEOUT(T)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (bus),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_done  (rsp_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int            last_gnt, gen_prob, def_wait;
  bit            pend_setup, in_xfer, resp_due, exp_to;
  int            pend_gnt, xfer_gnt, resp_gnt, acc_cnt, exp_len;
  logic [AW-1:0] x_addr;
  logic          x_write, x_err, exp_err;
  logic [DW-1:0] x_wdata, x_rdata, exp_rdata;
  tb_req_t       dq0[$];
  tb_req_t       dq1[$];
  int            wait_q[$];
  logic [DW-1:0] rdata_q[$];
  logic          err_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] elig);
    for (int k = 1; k <= N; k++) begin
      if (elig[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int pick_wait();
    if (wait_q.size() > 0) return wait_q.pop_front();
    if (def_wait >= 0) return def_wait;
    case ($urandom_range(5))
      0, 1:    return 0;
      2:       return 1;
      3:       return 2;
      4:       return T - 1;
      default: return T + 3;
    endcase
  endfunction

  task automatic next_request(input int i);
    tb_req_t r;
    bit have = 1'b0;
    r = '{w: 1'b0, a: '0, d: '0};
    if (i == 0 && dq0.size() > 0) begin
      r = dq0.pop_front(); have = 1'b1;
    end else if (i == 1 && dq1.size() > 0) begin
      r = dq1.pop_front(); have = 1'b1;
    end else if (int'($urandom_range(99)) < gen_prob) begin
      r.w = 1'($urandom); r.a = AW'($urandom); r.d = $urandom; have = 1'b1;
    end
    if (have) begin
      req_valid[i] = 1'b1;
      req_write[i] = r.w;
      req_addr[i]  = r.a;
      req_wdata[i] = r.d;
    end
  endtask

  task automatic drive_and_predict(input logic [N-1:0] done_mask, input bit bus_idle);
    logic [N-1:0] elig;
    int g;
    for (int i = 0; i < N; i++)
      if (!req_valid[i] && !done_mask[i]) next_request(i);
    if (bus_idle) begin
      elig = req_valid & ~done_mask;
      if (elig != '0) begin
        g          = rr_pick(last_gnt, elig);
        last_gnt   = g;
        pend_gnt   = g;
        pend_setup = 1'b1;
        x_addr     = req_addr[g] & 8'hFC;
        x_write    = req_write[g];
        x_wdata    = req_wdata[g];
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] done_mask;
    bit bus_idle;
    int w;
    @(negedge pclk);
    done_mask = '0;
    bus_idle  = 1'b1;
    if (resp_due) begin
      check_eq("rsp_done", 64'(rsp_done), 64'(1) << resp_gnt);
      check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
      done_mask[resp_gnt] = 1'b1;
      resp_due = 1'b0;
      req_valid[resp_gnt] = 1'b0;
      next_request(resp_gnt);
    end else begin
      check_eq("rsp_done_quiet", 64'(rsp_done), 64'd0);
    end
    if (pend_setup) begin
      pend_setup = 1'b0;
      bus_idle   = 1'b0;
      in_xfer    = 1'b1;
      xfer_gnt   = pend_gnt;
      acc_cnt    = 0;
      check_eq("setup_psel", 64'(bus.psel), 64'd1);
      check_eq("setup_penable", 64'(bus.penable), 64'd0);
      check_eq("setup_paddr", 64'(bus.paddr), 64'(x_addr));
      check_eq("setup_pwrite", 64'(bus.pwrite), 64'(x_write));
      check_eq("setup_pwdata", 64'(bus.pwdata), 64'(x_wdata));
      check_eq("setup_busy", 64'(busy), 64'd1);
      w       = pick_wait();
      exp_to  = (w >= T);
      exp_len = exp_to ? T : w + 1;
      x_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
      x_err   = (err_q.size() > 0) ? err_q.pop_front() : 1'($urandom);
      bus.pready  = 1'($urandom);
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom);
    end else if (in_xfer) begin
      bus_idle = 1'b0;
      acc_cnt++;
      check_eq("access_psel", 64'(bus.psel), 64'd1);
      check_eq("access_penable", 64'(bus.penable), 64'd1);
      check_eq("access_paddr", 64'(bus.paddr), 64'(x_addr));
      check_eq("access_pwrite", 64'(bus.pwrite), 64'(x_write));
      check_eq("access_pwdata", 64'(bus.pwdata), 64'(x_wdata));
      if (acc_cnt == exp_len) begin
        bus.pready  = !exp_to;
        bus.prdata  = x_rdata;
        bus.pslverr = exp_to ? 1'($urandom) : x_err;
        resp_due  = 1'b1;
        resp_gnt  = xfer_gnt;
        in_xfer   = 1'b0;
        exp_err   = exp_to ? 1'b1 : x_err;
        exp_rdata = (exp_to || x_write) ? '0 : x_rdata;
      end else begin
        bus.pready  = 1'b0;
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom);
      end
    end else begin
      check_eq("idle_psel", 64'(bus.psel), 64'd0);
      check_eq("idle_penable", 64'(bus.penable), 64'd0);
      check_eq("idle_busy", 64'(busy), 64'd0);
      bus.pready  = 1'($urandom);
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom);
    end
    drive_and_predict(done_mask, bus_idle);
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset(input int cycles);
    presetn     = 1'b0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    repeat (cycles) @(negedge pclk);
    check_eq("rst_psel", 64'(bus.psel), 64'd0);
    check_eq("rst_penable", 64'(bus.penable), 64'd0);
    check_eq("rst_pwrite", 64'(bus.pwrite), 64'd0);
    check_eq("rst_paddr", 64'(bus.paddr), 64'd0);
    check_eq("rst_pwdata", 64'(bus.pwdata), 64'd0);
    check_eq("rst_rsp_done", 64'(rsp_done), 64'd0);
    check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    pend_setup = 1'b0;
    in_xfer    = 1'b0;
    resp_due   = 1'b0;
    last_gnt   = N - 1;
  endtask

  task automatic release_reset();
    presetn = 1'b1;
    drive_and_predict('0, 1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;
    gen_prob = 0;
    def_wait = 0;

    // single zero-wait read on requester 0
    dq0.push_back('{w: 1'b0, a: 8'h13, d: 32'h0});
    rdata_q.push_back(32'hDEADBEEF);
    err_q.push_back(1'b0);
    wait_q.push_back(0);
    apply_reset(3);
    release_reset();
    run_steps(6);

    // both requesters continuously pending, zero wait
    gen_prob = 100;
    run_steps(30);
    gen_prob = 0;
    run_steps(12);

    // write, two wait states, slave error
    dq1.push_back('{w: 1'b1, a: 8'h44, d: 32'h12345678});
    wait_q.push_back(2);
    err_q.push_back(1'b1);
    run_steps(10);

    // timeout on requester 0 while requester 1 waits
    dq0.push_back('{w: 1'b0, a: 8'h50, d: 32'h0});
    dq1.push_back('{w: 1'b0, a: 8'h60, d: 32'h0});
    wait_q.push_back(T + 10);
    wait_q.push_back(0);
    run_steps(16);

    // pready arrives on the same cycle the timeout would fire
    dq0.push_back('{w: 1'b0, a: 8'h70, d: 32'h0});
    wait_q.push_back(T - 1);
    err_q.push_back(1'b0);
    run_steps(10);

    // requester keeps req_valid high with a new address after completion
    dq0.push_back('{w: 1'b0, a: 8'h30, d: 32'h0});
    dq0.push_back('{w: 1'b0, a: 8'h20, d: 32'h0});
    run_steps(12);

    // reset in the middle of a stalled ACCESS
    dq0.push_back('{w: 1'b0, a: 8'h84, d: 32'h0});
    dq1.push_back('{w: 1'b1, a: 8'h88, d: 32'hA5A5_0F0F});
    wait_q.push_back(T + 10);
    reached = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      step();
      if (in_xfer && acc_cnt == 2) reached = 1'b1;
    end
    check_eq("mid_reset_reached_access", 64'(reached), 64'd1);
    apply_reset(1);
    release_reset();
    run_steps(20);

    // randomized traffic
    def_wait = -1;
    gen_prob = 50;
    run_steps(800);
    gen_prob = 0;
    run_steps(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
# apb_arb_master

Shares one APB bus between N_REQ internal requesters. Each requester presents a single-word read or write request. A round-robin arbiter picks one, and an APB master FSM drives the `apb_if.master` port through the SETUP and ACCESS phases, honouring `pready`/`pslverr`. The block sits upstream of the peripheral APB slaves, including our `apb_slave` converters, and returns the read data and error status to the requester that was granted.

## Interface
- `N_REQ`, 2: number of requesters, 1..8.
- `BUS_ADDR_WIDTH`, 8: APB address width.
- `BUS_DATA_WIDTH`, 32: APB data width.
- `TIMEOUT`, 16: maximum ACCESS cycles to wait for `pready`; 0 disables the timeout.
- `pclk` input 1: the single clock.
- `presetn` input 1: synchronous, active-low reset.
- `apb` `apb_if.master`: drives `paddr`, `psel`, `penable`, `pwrite`, `pwdata`; samples `prdata`, `pready`, `pslverr`.
- `req_valid` input [N_REQ]: request pending; held high until the matching `rsp_done`.
- `req_write` input [N_REQ]: 1 = write, 0 = read.
- `req_addr` input [N_REQ][BUS_ADDR_WIDTH]: byte address; bits [1:0] are forced to 0 on the bus.
- `req_wdata` input [N_REQ][BUS_DATA_WIDTH]: write data.
- `rsp_done` output [N_REQ]: one-cycle completion pulse, one-hot or zero.
- `rsp_rdata` output BUS_DATA_WIDTH: read data, shared; valid when any `rsp_done` bit is high.
- `rsp_err` output 1: `pslverr` or timeout; valid with `rsp_done`.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Request fields must stay stable while `req_valid` is high. They are latched into internal registers at grant, and the bus is driven from those registers only.
- FSM states and transitions:
  - IDLE: if any eligible request is pending, grant it, latch its fields and go to SETUP.
  - SETUP: `psel`=1, `penable`=0; always go to ACCESS.
  - ACCESS: `psel`=1, `penable`=1.
    - On `pready`=1: capture `prdata` (reads only) and `pslverr`, then go to IDLE.
    - On timeout: go to IDLE with error set.
- Eligibility: in the IDLE cycle where `rsp_done[i]` is high, requester i is masked from arbitration. This prevents a stale `req_valid` from re-issuing the completed transfer.
- After seeing `rsp_done[i]`, requester i may drop `req_valid` or present a new request in the next cycle.
- Round robin: the search starts at index `last_grant`+1 modulo N_REQ. `last_grant` resets to N_REQ-1, so requester 0 has first priority after reset.
- Timeout: a counter clears on entering ACCESS and increments each ACCESS cycle with `pready`=0. When it reaches TIMEOUT the transfer aborts: `rsp_err`=1, `rsp_rdata`=0, bus returns to idle.
- Writes always return `rsp_rdata`=0.
- Reset values: `psel`, `penable`, `pwrite` = 0; `paddr`, `pwdata` = 0; `rsp_done`, `rsp_rdata`, `rsp_err` = 0; `busy` = 0; state IDLE; timeout counter 0.
- Reset mid-transfer: the transfer is abandoned in the next cycle, no `rsp_done` is issued, and outputs take their reset values.

## Timing
- Grant is decided combinationally in IDLE and registered, so SETUP is the cycle after `req_valid` is seen in IDLE.
- Zero-wait-state transfer: IDLE, SETUP, ACCESS = 3 cycles.
- `rsp_done` is registered and high in the IDLE cycle following the completing ACCESS cycle. Latency from `req_valid` (bus idle) to `rsp_done` is 3 cycles.
- Continuous requests issue one transfer every 3 cycles; each wait state adds 1 cycle.
- `psel`, `paddr`, `pwrite` and `pwdata` are constant from SETUP through the completing ACCESS cycle.
- `penable` is high only in ACCESS.
- Timeout with TIMEOUT=T: the abort takes effect after T ACCESS cycles with `pready` low. `rsp_done` arrives on the following cycle, together with `psel`=0.
- `pready` and the timeout reaching T in the same cycle: `pready` wins, and the normal response is returned.

## Structure
- `apb_arb_pkg`: state enum (IDLE/SETUP/ACCESS) and a request struct {write, addr, wdata} parameterised through localparams.
- Sub-module `rr_arbiter` (parameter N), shared with other arbiters:
  - inputs: `req` [N], `mask` [N], `advance`;
  - outputs: `grant` (one-hot), `grant_idx`.
  - `last_grant` updates on `advance`.

## Test plan
- Single read on requester 0, zero wait: `req_addr`=0x13 → SETUP at cycle 1 with `paddr`=0x10; ACCESS at cycle 2 with `prdata`=0xDEADBEEF; cycle 3 `rsp_done`=01, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Both requesters hold `req_valid` continuously (N_REQ=2) → grants alternate 0,1,0,1; one `rsp_done` every 3 cycles; no requester is granted twice in a row.
- Write with 2 wait states and `pslverr`=1 on completion → ACCESS lasts 3 cycles; `pwdata`=0x12345678 stable throughout; `rsp_err`=1, `rsp_rdata`=0.
- TIMEOUT=4, `pready` stuck low → 4 ACCESS cycles, then `psel`=0 and `rsp_done` with `rsp_err`=1; the next pending request is served normally.
- Requester keeps `req_valid` high after `rsp_done` with new `req_addr`=0x20 → a second transfer to 0x20 is issued; no duplicate transfer to the old address.
- `presetn` low during ACCESS → next cycle `psel`=`penable`=0, no `rsp_done`, `busy`=0; after release, requester 0 wins first.
